mod_n_serial_checker: RTL
=========================

Name: mod_n_serial_checker

Overview:
Serial divisibility checker: consumes one bit per accepted cycle and reports the running remainder of the received word modulo a parameterised DIVISOR, plus a divisible flag.
Generalises the team's fixed divide-by-3 MSB-first detector in three ways: configurable divisor, selectable MSB-first/LSB-first bit order, and valid/start/last word framing.
Sits beside the lab's serial arithmetic blocks as a stream monitor feeding result LEDs or a downstream checker.

Parameters:
DIVISOR, 3, modulus N; legal range 2..255.
RW, $clog2(DIVISOR), remainder width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_bit (and its framing inputs) are consumed this cycle.
in_bit  input  1  serial data bit.
in_start  input  1  first bit of a new word; qualified by in_valid.
in_last  input  1  final bit of the word; qualified by in_valid.
lsb_first  input  1  bit order: 0 = MSB-first, 1 = LSB-first. Sampled only on a word's first bit.
out_valid  output  1  registered; high the cycle after each accepted bit.
remainder  output  RW  registered running remainder of the received prefix mod DIVISOR.
divisible  output  1  registered; equals (remainder == 0).
word_done  output  1  registered; pulses together with out_valid for the in_last bit.

Behaviour:
- Reset (async assert, sync release): rem=0, weight=1, mode=0, first=1, out_valid=0, remainder=0, divisible=1, word_done=0.
- Latency: exactly 1 cycle from an accepted bit to its result. No backpressure; the block accepts one bit per cycle indefinitely.
- Internal state:
  - rem[RW-1:0]: running remainder.
  - weight[RW-1:0]: 2^k mod N, used in LSB-first mode only.
  - mode: latched bit order.
  - first: next accepted bit begins a new word.
- Word start: an accepted bit begins a new word if in_start=1 or first=1. For that bit, the base state is rem=0, weight=1, and mode=lsb_first.
  - in_start asserted mid-word abandons the current word without a word_done pulse.
  - in_start with in_valid=0 is ignored.
- Update for an accepted bit a, starting from the base state (r, w):
  - MSB-first: t = 2r + a; rem' = (t >= N) ? t - N : t.
  - LSB-first: t = r + (a ? w : 0); rem' = (t >= N) ? t - N : t. Then u = 2w; weight' = (u >= N) ? u - N : u.
  - All intermediate values are RW+1 bits wide. A single conditional subtract suffices because r, w < N. No divider is permitted.
- Outputs on the next edge: out_valid=1, remainder=rem', divisible=(rem'==0), word_done=in_last.
- After an in_last bit, first=1, so the next accepted bit starts a fresh word even without in_start. in_start and in_last together form a one-bit word.
- in_valid=0: all state holds; out_valid=0 and word_done=0; remainder and divisible hold their last values.
- lsb_first changes mid-word are ignored until the next word start.
- Reset mid-word discards the partial word; the first post-reset bit starts a new word.
- With DIVISOR=3, lsb_first=0 and no framing, the sequence of divisible values is bit-identical to the legacy mod-3 detector's output.

Decomposition:
- Package mod_n_pkg holds the mod-double/add helper function (the conditional-subtract step) and the MSB_FIRST/LSB_FIRST mode constants.
- One natural sub-module: mod_n_step, a combinational block (r, w, a, mode) -> (rem', weight'), so it can be exhaustively checked per DIVISOR.
- Framing, state registers and output registers stay in the top.

Test Plan:
- DIVISOR=3, MSB-first, in_start on first bit, bits 1,1,0 (value 6), last on bit 3 -> remainder 1,0,0; divisible 0,1,1; word_done only on the 3rd result.
- DIVISOR=3, LSB-first, bits 0,1,1 (value 6) -> remainder 0,2,0; divisible 1,0,1.
- DIVISOR=5, MSB-first, bits 1,0,1,0 (value 10) with an in_valid=0 gap after bit 2 -> remainder 1,2,0,0; out_valid low during the gap; outputs held.
- DIVISOR=7, MSB-first, word 1,1,1 with last, then immediately 1,0 without in_start -> 1,3,0, then new word 1,2.
- DIVISOR=3: reset_n pulsed low after bits 1,0 -> outputs immediately read remainder=0, divisible=1, out_valid=0; next bit 1 -> remainder 1.
- DIVISOR=3, MSB-first: in_start asserted mid-word on bit 1 after prefix 1,0 -> remainder 1 (prefix discarded, no word_done).

Source files
------------

// File: rtl/mod_n_pkg.sv
// Shared definitions for the serial mod-N divisibility checker.
//   bit_order_e : latched bit order of the word being received.
//   mod_add     : one modular addition step. It adds two operands that are each
//                 below N and makes at most one conditional subtract of N. No
//                 divider is used. The fixed width MAX_W covers DIVISOR up to
//                 255, so RW+1 <= 9.
package mod_n_pkg;

   localparam int MAX_W = 9;

   typedef enum logic {
      MSB_FIRST = 1'b0,
      LSB_FIRST = 1'b1
   } bit_order_e;

   function automatic logic [MAX_W-1:0] mod_add(input logic [MAX_W-1:0] x,
                                                input logic [MAX_W-1:0] y,
                                                input logic [MAX_W-1:0] n);
      logic [MAX_W-1:0] t;
      t = x + y;
      mod_add = (t >= n) ? (t - n) : t;
   endfunction

endpackage

// File: rtl/mod_n_step.sv
// Combinational single-bit update of the running remainder.
//   r, w       : current remainder and LSB-first weight (2^k mod N), both < N
//   a          : incoming bit
//   mode       : bit order of the current word
//   rem_nxt    : remainder after folding in a
//   weight_nxt : next weight (LSB-first only; in MSB-first mode it passes w through)
module mod_n_step
   import mod_n_pkg::*;
#(
   parameter int DIVISOR = 3,
   parameter int RW      = $clog2(DIVISOR)
) (
   input  logic [RW-1:0] r,
   input  logic [RW-1:0] w,
   input  logic          a,
   input  bit_order_e    mode,
   output logic [RW-1:0] rem_nxt,
   output logic [RW-1:0] weight_nxt
);

   localparam logic [MAX_W-1:0] N_W = MAX_W'(DIVISOR);

   logic [MAX_W-1:0] r_w;
   logic [MAX_W-1:0] w_w;
   logic [MAX_W-1:0] a_w;
   logic [MAX_W-1:0] rem_w;
   logic [MAX_W-1:0] wgt_w;
   logic             unused_hi;

   always_comb begin
      r_w   = MAX_W'(r);
      w_w   = MAX_W'(w);
      a_w   = MAX_W'(a);
      rem_w = '0;
      wgt_w = w_w;
      if (mode == MSB_FIRST) begin
         // 2r + a: r < N <= 255, so 2r + 1 fits in MAX_W bits.
         rem_w = mod_add(r_w << 1, a_w, N_W);
      end else begin
         rem_w = mod_add(r_w, a ? w_w : '0, N_W);
         wgt_w = mod_add(w_w, w_w, N_W);
      end
      rem_nxt    = rem_w[RW-1:0];
      weight_nxt = wgt_w[RW-1:0];
   end

   // After the subtract the results are below N, so the bits above RW are always zero.
   assign unused_hi = ^{rem_w[MAX_W-1:RW], wgt_w[MAX_W-1:RW]};

endmodule

// File: rtl/mod_n_serial_checker.sv
// Serial divisibility checker. It takes one bit per cycle when in_valid is high
// and reports the running remainder of the received word modulo DIVISOR. The
// result appears one cycle after each accepted bit.
//   clk, reset_n  : rising-edge clock; async active-low reset
//   in_valid      : consume in_bit / in_start / in_last this cycle
//   in_bit        : serial data bit
//   in_start      : first bit of a new word (abandons any partial word)
//   in_last       : final bit of the word
//   lsb_first     : bit order; sampled only on a word's first bit
//   out_valid     : high the cycle after each accepted bit
//   remainder     : running remainder of the received prefix mod DIVISOR
//   divisible     : remainder == 0
//   word_done     : pulses with out_valid for the in_last bit
module mod_n_serial_checker
   import mod_n_pkg::*;
#(
   parameter  int DIVISOR = 3,
   localparam int RW      = $clog2(DIVISOR)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   input  logic          in_bit,
   input  logic          in_start,
   input  logic          in_last,
   input  logic          lsb_first,
   output logic          out_valid,
   output logic [RW-1:0] remainder,
   output logic          divisible,
   output logic          word_done
);

   logic [RW-1:0] rem_q,    rem_d;
   logic [RW-1:0] weight_q, weight_d;
   bit_order_e    mode_q,   mode_d;
   logic          first_q,  first_d;
   logic          out_valid_q, out_valid_d;
   logic          divisible_q, divisible_d;
   logic          word_done_q, word_done_d;

   logic          word_start;
   logic [RW-1:0] base_rem;
   logic [RW-1:0] base_weight;
   bit_order_e    base_mode;
   logic [RW-1:0] step_rem;
   logic [RW-1:0] step_weight;

   // A word starts on any accepted bit that has in_start set or that follows an
   // in_last bit or a reset. That bit is folded into a clean base state.
   always_comb begin
      word_start  = in_valid & (in_start | first_q);
      base_rem    = word_start ? '0 : rem_q;
      base_weight = word_start ? RW'(1) : weight_q;
      base_mode   = word_start ? bit_order_e'(lsb_first) : mode_q;
   end

   mod_n_step #(
      .DIVISOR (DIVISOR),
      .RW      (RW)
   ) u_step (
      .r          (base_rem),
      .w          (base_weight),
      .a          (in_bit),
      .mode       (base_mode),
      .rem_nxt    (step_rem),
      .weight_nxt (step_weight)
   );

   always_comb begin
      rem_d       = rem_q;
      weight_d    = weight_q;
      mode_d      = mode_q;
      first_d     = first_q;
      out_valid_d = 1'b0;
      divisible_d = divisible_q;
      word_done_d = 1'b0;
      if (in_valid) begin
         rem_d       = step_rem;
         weight_d    = step_weight;
         mode_d      = base_mode;
         first_d     = in_last;
         out_valid_d = 1'b1;
         divisible_d = (step_rem == '0);
         word_done_d = in_last;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem_q       <= '0;
         weight_q    <= RW'(1);
         mode_q      <= MSB_FIRST;
         first_q     <= 1'b1;
         out_valid_q <= 1'b0;
         divisible_q <= 1'b1;
         word_done_q <= 1'b0;
      end else begin
         rem_q       <= rem_d;
         weight_q    <= weight_d;
         mode_q      <= mode_d;
         first_q     <= first_d;
         out_valid_q <= out_valid_d;
         divisible_q <= divisible_d;
         word_done_q <= word_done_d;
      end
   end

   // The running remainder register is the reported remainder. It holds across
   // in_valid gaps in the same way the output would.
   assign out_valid = out_valid_q;
   assign remainder = rem_q;
   assign divisible = divisible_q;
   assign word_done = word_done_q;

endmodule
